// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: decodes ASCII commands arriving from the UART RX FIFO into
// CPU control pulses and a hex start address.
//   S/s      -> step pulse
//   R/r      -> cpu_reset pulse
//   A/a      -> begin an address of exactly HEX_DIGITS hex digits, ended by CR or LF
//   CR/LF/sp -> ignored while in command mode
// Optional feature macro: UART_ECHO_EN. When it is defined, each accepted
// byte is echoed to the TX FIFO, and the echo waits while tx_full is high.
//
// state   | meaning
// --------+--------------------------------------------------------------
// GET     | wait for an RX byte, latch it and decode it into registered pulses
// DECODE  | rd and the action pulse are visible for this one cycle
// ECHO    | wait for TX room, then push the accepted byte (UART_ECHO_EN only)
module uart_cmd_rx #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          HEX_DIGITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_empty,
    input  logic [7:0]  r_data,
    output logic        rd,
    input  logic        tx_full,
    output logic [7:0]  w_data,
    output logic        wr,
    output logic        step,
    output logic        cpu_reset,
    output logic [31:0] start_addr,
    output logic        addr_load,
    output logic        err
);

    localparam logic [3:0] HEX_CNT = 4'(HEX_DIGITS);

    typedef enum logic [1:0] {
        ST_GET    = 2'd0,
        ST_DECODE = 2'd1,
        ST_ECHO   = 2'd2
    } state_t;

    typedef enum logic {
        MODE_CMD  = 1'b0,
        MODE_ADDR = 1'b1
    } mode_t;

    state_t      state_q, state_d;
    mode_t       mode_q, mode_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;
    logic [7:0]  byte_q, byte_d;
    logic [31:0] addr_q, addr_d;
    logic        rd_q, rd_d;
    logic        step_q, step_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        addr_load_q, addr_load_d;
    logic        err_q, err_d;
    logic        wr_q, wr_d;
    logic [7:0]  w_data_q, w_data_d;

    function automatic logic is_hex(input logic [7:0] b);
        return (b >= 8'h30 && b <= 8'h39) ||
               (b >= 8'h41 && b <= 8'h46) ||
               (b >= 8'h61 && b <= 8'h66);
    endfunction

    // Letters A-F and a-f both have 1..6 in their low nibble, so adding 9
    // gives 10..15.
    function automatic logic [3:0] hex_nibble(input logic [7:0] b);
        return (b <= 8'h39) ? b[3:0] : (b[3:0] + 4'd9);
    endfunction

    // Next-state, datapath and pulse decode. The byte is decoded on the GET
    // edge, so its pulses appear registered in the DECODE cycle.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        byte_d      = byte_q;
        addr_d      = addr_q;
        rd_d        = 1'b0;
        step_d      = 1'b0;
        cpu_reset_d = 1'b0;
        addr_load_d = 1'b0;
        err_d       = 1'b0;
        wr_d        = 1'b0;
        w_data_d    = w_data_q;
        case (state_q)
            ST_GET: begin
                if (!rx_empty) begin
                    byte_d  = r_data;
                    rd_d    = 1'b1;
                    state_d = ST_DECODE;
                    if (mode_q == MODE_CMD) begin
                        case (r_data)
                            8'h53, 8'h73: step_d      = 1'b1;
                            8'h52, 8'h72: cpu_reset_d = 1'b1;
                            8'h41, 8'h61: begin
                                acc_d  = '0;
                                cnt_d  = '0;
                                mode_d = MODE_ADDR;
                            end
                            8'h0D, 8'h0A, 8'h20: ;
                            default: err_d = 1'b1;
                        endcase
                    end else begin
                        if (is_hex(r_data) && cnt_q < HEX_CNT) begin
                            acc_d = {acc_q[27:0], hex_nibble(r_data)};
                            cnt_d = cnt_q + 4'd1;
                        end else if ((r_data == 8'h0D || r_data == 8'h0A) &&
                                     cnt_q == HEX_CNT) begin
                            addr_d      = acc_q;
                            addr_load_d = 1'b1;
                            mode_d      = MODE_CMD;
                        end else begin
                            err_d  = 1'b1;
                            mode_d = MODE_CMD;
                        end
                    end
                end
            end
            ST_DECODE: begin
                state_d = ST_GET;
`ifdef UART_ECHO_EN
                if (!err_q) state_d = ST_ECHO;
`endif
            end
`ifdef UART_ECHO_EN
            ST_ECHO: begin
                if (!tx_full) begin
                    wr_d     = 1'b1;
                    w_data_d = byte_q;
                    state_d  = ST_GET;
                end
            end
`endif
            default: state_d = ST_GET;
        endcase
    end

    // State and output registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_GET;
            mode_q      <= MODE_CMD;
            cnt_q       <= '0;
            acc_q       <= '0;
            byte_q      <= '0;
            addr_q      <= RESET_ADDR;
            rd_q        <= 1'b0;
            step_q      <= 1'b0;
            cpu_reset_q <= 1'b0;
            addr_load_q <= 1'b0;
            err_q       <= 1'b0;
            wr_q        <= 1'b0;
            w_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            byte_q      <= byte_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            step_q      <= step_d;
            cpu_reset_q <= cpu_reset_d;
            addr_load_q <= addr_load_d;
            err_q       <= err_d;
            wr_q        <= wr_d;
            w_data_q    <= w_data_d;
        end
    end

    assign rd         = rd_q;
    assign step       = step_q;
    assign cpu_reset  = cpu_reset_q;
    assign addr_load  = addr_load_q;
    assign err        = err_q;
    assign start_addr = addr_q;

`ifdef UART_ECHO_EN
    assign wr     = wr_q;
    assign w_data = w_data_q;
`else
    // Without echo the TX side is tied off. The echo registers stay at
    // their reset values and are not connected to any output.
    logic unused_echo;
    assign unused_echo = ^{tx_full, byte_q, wr_q, w_data_q};
    assign wr     = 1'b0;
    assign w_data = 8'h00;
`endif

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: RX FIFO model, directed command strings, and a
// scoreboard of expected pulses (and echoes when UART_ECHO_EN is defined).
module tb_uart_cmd_rx;

    logic        clk;
    logic        reset;
    logic        rx_empty;
    logic [7:0]  r_data;
    logic        rd;
    logic        tx_full;
    logic [7:0]  w_data;
    logic        wr;
    logic        step;
    logic        cpu_reset;
    logic [31:0] start_addr;
    logic        addr_load;
    logic        err;

    uart_cmd_rx dut (
        .clk        (clk),
        .reset      (reset),
        .rx_empty   (rx_empty),
        .r_data     (r_data),
        .rd         (rd),
        .tx_full    (tx_full),
        .w_data     (w_data),
        .wr         (wr),
        .step       (step),
        .cpu_reset  (cpu_reset),
        .start_addr (start_addr),
        .addr_load  (addr_load),
        .err        (err)
    );

    // kind bits: {step, cpu_reset, addr_load, err}
    localparam logic [3:0] K_STEP = 4'b1000;
    localparam logic [3:0] K_RST  = 4'b0100;
    localparam logic [3:0] K_LOAD = 4'b0010;
    localparam logic [3:0] K_ERR  = 4'b0001;

    typedef struct {
        logic [3:0]  kind;
        logic [31:0] addr;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] echo_q[$];
    logic [7:0] rx_q[$];

    int n_chk;
    int n_fail;
    int rd_cnt;
    int rd_double;
    int wr_bad;
    logic prev_rd;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic expect_ev(input logic [3:0] kind, input logic [31:0] addr);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        exp_q.push_back(e);
    endtask

    // rj marks rejected bytes with 'x'; every other byte is expected to be echoed.
    task automatic send(input string s, input string rj);
        @(negedge clk);
        for (int i = 0; i < s.len(); i++) begin
            rx_q.push_back(s[i]);
`ifdef UART_ECHO_EN
            if (rj[i] != "x") echo_q.push_back(s[i]);
`endif
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 500 && rx_q.size() != 0; i++) @(negedge clk);
        repeat (6) @(negedge clk);
        n_chk++;
        if (rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_%s: %0d bytes still queued, required 0", name, rx_q.size());
        end
    endtask

    initial begin
        reset    = 1'b1;
        tx_full  = 1'b0;
        rx_empty = 1'b1;
        r_data   = 8'h00;
        n_chk    = 0;
        n_fail   = 0;
        rd_cnt   = 0;
        rd_double = 0;
        wr_bad   = 0;
        prev_rd  = 1'b0;

        fork
            // RX FIFO model: pops on rd, presents the head byte between edges.
            forever begin
                @(negedge clk);
                if (rd && rx_q.size() != 0) void'(rx_q.pop_front());
                rx_empty = (rx_q.size() == 0);
                r_data   = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
            end
            // Monitor / scoreboard.
            forever begin
                ev_t e;
                @(negedge clk);
                if (reset) begin
                    n_chk++;
                    if (rd | step | cpu_reset | addr_load | err | wr) begin
                        n_fail++;
                        $display("FAIL in_reset: rd=%b pulses=%b wr=%b, required all 0",
                                 rd, {step, cpu_reset, addr_load, err}, wr);
                    end
                end else begin
                    if (rd) rd_cnt++;
                    if (rd && prev_rd) rd_double++;
                    if (step | cpu_reset | addr_load | err) begin
                        n_chk++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL ev_unexpected: pulses=%b addr=%h, required no pulse",
                                     {step, cpu_reset, addr_load, err}, start_addr);
                        end else begin
                            e = exp_q.pop_front();
                            if ({step, cpu_reset, addr_load, err} !== e.kind ||
                                start_addr !== e.addr || rd !== 1'b1) begin
                                n_fail++;
                                $display("FAIL ev: pulses=%b addr=%h rd=%b, required pulses=%b addr=%h rd=1",
                                         {step, cpu_reset, addr_load, err}, start_addr, rd,
                                         e.kind, e.addr);
                            end
                        end
                    end
                    if (wr) begin
`ifdef UART_ECHO_EN
                        n_chk++;
                        if (echo_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL echo_unexpected: w_data=%h, required no wr", w_data);
                        end else begin
                            logic [7:0] eb;
                            eb = echo_q.pop_front();
                            if (w_data !== eb) begin
                                n_fail++;
                                $display("FAIL echo: w_data=%h, required %h", w_data, eb);
                            end
                        end
`else
                        wr_bad++;
`endif
                    end
                end
                prev_rd = rd;
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        n_chk++;
        if ({rd, wr, step, cpu_reset, addr_load, err} !== 6'b0 || w_data !== 8'h00 ||
            start_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: ctl=%b w_data=%h addr=%h, required 0/00/00000000",
                     {rd, wr, step, cpu_reset, addr_load, err}, w_data, start_addr);
        end
        reset = 1'b0;

        // Single step
        expect_ev(K_STEP, 32'h0);
        send("S", ".");
        drain("step");

        // Address load
        expect_ev(K_LOAD, 32'h0040_002C);
        send("A0040002C\015", "..........");
        drain("addr");

        // Ignored whitespace, then an unknown command byte
        expect_ev(K_ERR, 32'h0040_002C);
        send(" \015\012Z", "...x");
        drain("ignore");

        // Bad digit, then lower-case reset
        expect_ev(K_ERR, 32'h0040_002C);
        expect_ev(K_RST, 32'h0040_002C);
        send("A12Gr", "...x.");
        drain("bad_digit");

        // Early LF
        expect_ev(K_ERR, 32'h0040_002C);
        send("A123\012", "....x");
        drain("early_lf");

        // Ninth digit
        expect_ev(K_ERR, 32'h0040_002C);
        send("A123456789", ".........x");
        drain("ninth");

        // Lower-case address with LF, then upper-case reset
        expect_ev(K_LOAD, 32'hDEAD_BEEF);
        expect_ev(K_RST, 32'hDEAD_BEEF);
        send("adeadbeef\012R", "...........");
        drain("lower");

        // Reset mid-address
        send("A1234", ".....");
        drain("partial");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_chk++;
        if (start_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_addr: start_addr=%h, required 00000000", start_addr);
        end
        for (int i = 0; i < 8; i++) expect_ev(K_ERR, 32'h0);
        send("00000000\015", "xxxxxxxx.");
        drain("after_reset");

        // Reset in the same cycle as a byte: the byte waits until reset is released
        @(negedge clk);
        reset = 1'b1;
        expect_ev(K_STEP, 32'h0);
        rx_q.push_back(8'h73);
`ifdef UART_ECHO_EN
        echo_q.push_back(8'h73);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        drain("reset_wins");

`ifdef UART_ECHO_EN
        // Echo backpressure
        begin
            int rd0;
            tx_full = 1'b1;
            rd0 = rd_cnt;
            expect_ev(K_STEP, 32'h0);
            expect_ev(K_STEP, 32'h0);
            send("sS", "..");
            repeat (12) @(negedge clk);
            n_chk++;
            if (rd_cnt != rd0 + 1 || echo_q.size() != 2) begin
                n_fail++;
                $display("FAIL echo_hold: rd pulses=%0d echoes pending=%0d, required 1 and 2",
                         rd_cnt - rd0, echo_q.size());
            end
            tx_full = 1'b0;
            drain("echo");
            n_chk++;
            if (echo_q.size() != 0) begin
                n_fail++;
                $display("FAIL echo_left: %0d echoes pending, required 0", echo_q.size());
            end
        end
`else
        n_chk++;
        if (wr_bad != 0) begin
            n_fail++;
            $display("FAIL wr_tied: wr seen %0d times, required 0", wr_bad);
        end
`endif

        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL ev_missing: %0d expected pulses never seen, required 0", exp_q.size());
        end
        n_chk++;
        if (rd_double != 0) begin
            n_fail++;
            $display("FAIL rd_width: %0d back-to-back rd cycles, required 0", rd_double);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
